// File: rtl/mchan_fifo_burst_reader.sv
// ----------------------------------------------------------------------------
// mchan_fifo_burst_reader
//
// Pop-side consumer for mchan_fifo. A command carrying LEN (beats-1) makes the
// block pop exactly LEN+1 beats from the FIFO through its req/gnt pop port.
// The beats are forwarded in order on a valid/ready stream, and the final beat
// carries a last flag. A 2-entry output buffer decouples the downstream ready
// from the FIFO pop request. Because of that buffer, fifo_req_o is built only
// from registered state.
//
// Ports
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   cmd_req_i    burst command request
//   cmd_len_i    number of beats minus one (0 => single beat)
//   cmd_gnt_o    command accepted when cmd_req_i && cmd_gnt_o (high in IDLE)
//   fifo_dat_i   FIFO head data
//   fifo_gnt_i   FIFO not empty
//   fifo_req_o   FIFO pop request
//   out_data_o   stream data (head of the output buffer)
//   out_last_o   final beat of the burst
//   out_valid_o  stream valid (output buffer not empty)
//   out_ready_i  stream ready
//   busy_o       a burst is in progress (state != IDLE)
//   done_o       one-cycle pulse in the cycle after the last-beat handshake
// ----------------------------------------------------------------------------
module mchan_fifo_burst_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_req_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  output logic                  cmd_gnt_o,
  input  logic [DATA_WIDTH-1:0] fifo_dat_i,
  input  logic                  fifo_gnt_i,
  output logic                  fifo_req_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_last_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                 state;
  logic [LEN_WIDTH-1:0]   beats_left;
  logic [DATA_WIDTH-1:0]  buf_data [2];
  logic                   buf_last [2];
  logic                   wr_ptr;
  logic                   rd_ptr;
  logic [1:0]             count;
  logic                   pop;
  logic                   hs;

  assign cmd_gnt_o   = (state == IDLE);
  assign busy_o      = (state != IDLE);
  // The request is formed only from the state and the buffer occupancy. When
  // the buffer is full, no request is made, even if a handshake frees an entry
  // in the same cycle.
  assign fifo_req_o  = (state == RUN) && (count != 2'd2);
  assign pop         = fifo_req_o && fifo_gnt_i;
  assign out_valid_o = (count != 2'd0);
  assign hs          = out_valid_o && out_ready_i;
  assign out_data_o  = buf_data[rd_ptr];
  assign out_last_o  = buf_last[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      beats_left <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      done_o     <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_last[i] <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (cmd_req_i) begin
            beats_left <= cmd_len_i;
            state      <= RUN;
          end
        end
        RUN: begin
          // The count stops at zero. It does not wrap, so a full-length burst
          // of 2**LEN_WIDTH beats ends correctly.
          if (pop) begin
            if (beats_left == '0) begin
              state <= DRAIN;
            end else begin
              beats_left <= beats_left - 1'b1;
            end
          end
        end
        DRAIN: begin
          if (hs && out_last_o) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // The last beat is popped in RUN and is seen at the buffer head no
      // earlier than the following cycle. Its handshake therefore always
      // happens in DRAIN.
      done_o <= (state == DRAIN) && hs && out_last_o;

      if (pop) begin
        buf_data[wr_ptr] <= fifo_dat_i;
        buf_last[wr_ptr] <= (beats_left == '0);
        wr_ptr           <= ~wr_ptr;
      end
      if (hs) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, pop} - {1'b0, hs};
    end
  end

endmodule

// File: tb/tb_mchan_fifo_burst_reader.sv
// ----------------------------------------------------------------------------
// Directed testbench for mchan_fifo_burst_reader. A behavioural FIFO model
// feeds the pop port, and a monitor records every stream handshake. Expected
// values are written out by hand for each step.
// ----------------------------------------------------------------------------
module tb_mchan_fifo_burst_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_req;
  logic [7:0]  cmd_len;
  logic        cmd_gnt;
  logic [31:0] fifo_dat;
  logic        fifo_gnt;
  logic        fifo_req;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mchan_fifo_burst_reader #(.DATA_WIDTH(32), .LEN_WIDTH(8)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cmd_req_i   (cmd_req),
    .cmd_len_i   (cmd_len),
    .cmd_gnt_o   (cmd_gnt),
    .fifo_dat_i  (fifo_dat),
    .fifo_gnt_i  (fifo_gnt),
    .fifo_req_o  (fifo_req),
    .out_data_o  (out_data),
    .out_last_o  (out_last),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .busy_o      (busy),
    .done_o      (done)
  );

  // The FIFO model shares its reset with the DUT. On reset, all unread words
  // are discarded.
  logic [31:0] fifo_mem [0:1023];
  int wr_idx = 0;
  int rd_idx;
  assign fifo_gnt = (rd_idx != wr_idx);
  assign fifo_dat = fifo_mem[rd_idx];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_idx <= wr_idx;
    else if (fifo_req && fifo_gnt) rd_idx <= rd_idx + 1;
  end

  // Monitor: records handshakes, pops and done pulses, and counts violations
  // of the stall-stability and full-buffer rules.
  int cyc = 0, pop_cnt = 0, hs_cnt = 0, done_cnt = 0, done_cyc = 0;
  int stall_viol = 0, occ_viol = 0, occ = 0;
  logic [31:0] cap_data [0:1023];
  logic        cap_last [0:1023];
  int          cap_cyc  [0:1023];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;

  always @(posedge clk) begin
    cyc++;
    if (rst_n) begin
      if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last))
        stall_viol++;
      if (occ >= 2 && fifo_req) occ_viol++;
      if (out_valid && out_ready) begin
        cap_data[hs_cnt] = out_data;
        cap_last[hs_cnt] = out_last;
        cap_cyc[hs_cnt]  = cyc;
        hs_cnt++;
      end
      if (fifo_req && fifo_gnt) pop_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      occ = occ + ((fifo_req && fifo_gnt) ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end else begin
      occ        = 0;
      prev_stall = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] d);
    fifo_mem[wr_idx] = d;
    wr_idx++;
  endtask

  // Called at a falling edge. It presents a command for one cycle and then
  // checks that the command was accepted.
  task automatic run_cmd(input logic [7:0] len);
    cmd_req = 1'b1;
    cmd_len = len;
    @(negedge clk);
    cmd_req = 1'b0;
    chk("cmd_accept_gnt_busy", {cmd_gnt, busy}, 2'b01);
  endtask

  task automatic wait_done(input int budget, input bit tog);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      if (!done && tog) out_ready = ~out_ready;
      n++;
    end
    chk("done_seen", done, 1'b1);
  endtask

  int b, p, d, n, lasts, busy_low;

  initial begin
    rst_n = 1'b0; cmd_req = 1'b0; cmd_len = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {cmd_gnt, fifo_req, out_valid, out_last, busy, done}, 6'b100000);
    chk("rst_data", out_data, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: four-beat burst at full throughput.
    for (int i = 0; i < 4; i++) push(32'hA0 + i);
    b = hs_cnt; p = pop_cnt; d = done_cnt;
    out_ready = 1'b1;
    run_cmd(8'd3);
    wait_done(50, 1'b0);
    repeat (2) @(negedge clk);
    chk("t1_beats", hs_cnt - b, 4);
    for (int i = 0; i < 4; i++) chk("t1_data", cap_data[b+i], 32'hA0 + i);
    chk("t1_last", {cap_last[b], cap_last[b+1], cap_last[b+2], cap_last[b+3]}, 4'b0001);
    chk("t1_consecutive", cap_cyc[b+3] - cap_cyc[b], 3);
    chk("t1_done_timing", done_cyc, cap_cyc[b+3] + 1);
    chk("t1_pops", pop_cnt - p, 4);
    chk("t1_done_cnt", done_cnt - d, 1);

    // 2: single-beat burst leaves Y in the FIFO. The next command is issued
    //    in the same cycle as done and consumes Y.
    push(32'hB0); push(32'hB1);
    b = hs_cnt; p = pop_cnt; d = done_cnt;
    run_cmd(8'd0);
    wait_done(50, 1'b0);
    chk("t2_fifo_left", wr_idx - rd_idx, 1);
    chk("t2_gnt_on_done", cmd_gnt, 1'b1);
    run_cmd(8'd0);
    wait_done(50, 1'b0);
    repeat (2) @(negedge clk);
    chk("t2_beats", hs_cnt - b, 2);
    chk("t2_x", {cap_data[b], cap_last[b]}, {32'hB0, 1'b1});
    chk("t2_y", {cap_data[b+1], cap_last[b+1]}, {32'hB1, 1'b1});
    chk("t2_pops", pop_cnt - p, 2);
    chk("t2_done_cnt", done_cnt - d, 2);

    // 4: the FIFO starts empty, then receives one word every three cycles.
    b = hs_cnt; p = pop_cnt; d = done_cnt;
    run_cmd(8'd2);
    repeat (4) @(negedge clk);
    chk("t4_empty_wait", {out_valid, fifo_req, busy}, 3'b011);
    chk("t4_no_pop", pop_cnt - p, 0);
    for (int k = 0; k < 3; k++) begin
      push(32'hD0 + k);
      if (k < 2) repeat (3) @(negedge clk);
    end
    wait_done(20, 1'b0);
    repeat (2) @(negedge clk);
    chk("t4_beats", hs_cnt - b, 3);
    for (int i = 0; i < 3; i++) chk("t4_data", cap_data[b+i], 32'hD0 + i);
    chk("t4_last", {cap_last[b], cap_last[b+1], cap_last[b+2]}, 3'b001);
    chk("t4_pops", pop_cnt - p, 3);
    chk("t4_done_cnt", done_cnt - d, 1);

    // 5: maximum-length burst of 256 beats.
    for (int i = 0; i < 256; i++) push(32'h500 + i);
    b = hs_cnt; p = pop_cnt;
    run_cmd(8'd255);
    n = 0; busy_low = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      if (!done && !busy) busy_low++;
      n++;
    end
    chk("t5_done_seen", done, 1'b1);
    repeat (2) @(negedge clk);
    chk("t5_beats", hs_cnt - b, 256);
    for (int i = 0; i < 256; i++) chk("t5_data", cap_data[b+i], 32'h500 + i);
    lasts = 0;
    for (int i = 0; i < 256; i++) if (cap_last[b+i]) lasts++;
    chk("t5_last_count", lasts, 1);
    chk("t5_last_pos", cap_last[b+255], 1'b1);
    chk("t5_pops", pop_cnt - p, 256);
    chk("t5_busy", busy_low, 0);

    // 3: eight-beat burst with ready toggling 1010... The FIFO holds more
    //    words than the burst requests.
    for (int i = 0; i < 10; i++) push(32'hC0 + i);
    b = hs_cnt; p = pop_cnt;
    out_ready = 1'b1;
    run_cmd(8'd7);
    wait_done(100, 1'b1);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("t3_beats", hs_cnt - b, 8);
    for (int i = 0; i < 8; i++) chk("t3_data", cap_data[b+i], 32'hC0 + i);
    lasts = 0;
    for (int i = 0; i < 8; i++) if (cap_last[b+i]) lasts++;
    chk("t3_last", {lasts[7:0], cap_last[b+7]}, {8'd1, 1'b1});
    chk("t3_pops", pop_cnt - p, 8);
    chk("t3_stall_stable", stall_viol, 0);
    chk("t3_full_no_req", occ_viol, 0);
    chk("t3_fifo_left", wr_idx - rd_idx, 2);

    // 6: reset after 2 of 5 beats. The first beats are C8 and C9, which are
    //    left over from test 3.
    for (int i = 0; i < 5; i++) push(32'hE0 + i);
    b = hs_cnt;
    run_cmd(8'd4);
    n = 0;
    while (hs_cnt - b < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_two_beats", hs_cnt - b, 2);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ctrl", {cmd_gnt, fifo_req, out_valid, out_last, busy, done}, 6'b100000);
    chk("t6_rst_data", out_data, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_gnt_after", cmd_gnt, 1'b1);
    chk("t6_discarded", hs_cnt - b, 2);
    chk("t6_first_beats", {cap_data[b], cap_data[b+1]}, {32'hC8, 32'hC9});
    push(32'hF0); push(32'hF1);
    b = hs_cnt; d = done_cnt;
    run_cmd(8'd1);
    wait_done(50, 1'b0);
    repeat (2) @(negedge clk);
    chk("t6_next_beats", hs_cnt - b, 2);
    chk("t6_next_data", {cap_data[b], cap_data[b+1]}, {32'hF0, 32'hF1});
    chk("t6_next_last", {cap_last[b], cap_last[b+1]}, 2'b01);
    chk("t6_next_done", done_cnt - d, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
